// File: rtl/present_pkg.sv
// PRESENT-80 shared types, S-box tables, FSM encoding and key-schedule helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a. Optional decrypt states are gated by PRESENT_DECRYPT_EN.
package present_pkg;

    localparam int ROUNDS = 31;
    localparam logic [4:0] LAST_RND = 5'(ROUNDS);

    typedef logic [63:0] present_state_t;
    typedef logic [79:0] present_key_t;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam logic [3:0] SBOX_INV [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

`ifdef PRESENT_DECRYPT_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ENC    = 3'd1,
        ST_FINAL  = 3'd2,
        ST_KEYGEN = 3'd3,
        ST_DEC    = 3'd4
    } present_fsm_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ENC    = 3'd1,
        ST_FINAL  = 3'd2
    } present_fsm_e;
`endif

    // Bit b of the S-layer output lands at position 16*b mod 63 (bit 63 fixed).
    // Multiplying by 16 modulo 63 is a 6-bit rotate-left by 4, which also maps 63 to 63.
    function automatic logic [5:0] p_pos(input logic [5:0] b);
        return {b[1:0], b[5:2]};
    endfunction

    // Forward key schedule step for round counter rc.
    function automatic present_key_t key_update(input present_key_t k, input logic [4:0] rc);
        present_key_t t;
        t          = {k[18:0], k[79:19]};
        t[79:76]   = SBOX[t[79:76]];
        t[19:15]   = t[19:15] ^ rc;
        return t;
    endfunction

    // Exact inverse of key_update for the same rc.
    function automatic present_key_t key_invupdate(input present_key_t k, input logic [4:0] rc);
        present_key_t t;
        t          = k;
        t[19:15]   = t[19:15] ^ rc;
        t[79:76]   = SBOX_INV[t[79:76]];
        t          = {t[60:0], t[79:61]};
        return t;
    endfunction

endpackage

// File: rtl/present_round.sv
// PRESENT round core: S-layer then P-layer, or P^-1 then S^-1 when dir=1 (PRESENT_DECRYPT_EN).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the controller decides when the result is captured.
module present_round
    import present_pkg::*;
(
    input  logic           dir,
    input  present_state_t din,
    output present_state_t dout
);

    present_state_t s_out;
    present_state_t p_out;

    // Forward path: nibble-wise S-box followed by the bit permutation.
    always_comb begin
        s_out = '0;
        p_out = '0;
        for (int n = 0; n < 16; n++) begin
            s_out[n*4 +: 4] = SBOX[din[n*4 +: 4]];
        end
        for (int b = 0; b < 64; b++) begin
            p_out[p_pos(6'(b))] = s_out[6'(b)];
        end
    end

`ifdef PRESENT_DECRYPT_EN
    present_state_t pi_out;
    present_state_t si_out;

    // Inverse path: undo the permutation first, then the S-box.
    always_comb begin
        pi_out = '0;
        si_out = '0;
        for (int b = 0; b < 64; b++) begin
            pi_out[6'(b)] = din[p_pos(6'(b))];
        end
        for (int n = 0; n < 16; n++) begin
            si_out[n*4 +: 4] = SBOX_INV[pi_out[n*4 +: 4]];
        end
    end

    assign dout = dir ? si_out : p_out;
`else
    logic unused_dir;
    assign unused_dir = dir;
    assign dout       = p_out;
`endif

endmodule

// File: rtl/present80_round_ctrl.sv
// Iterative PRESENT-80 engine: one round per clock, on-the-fly key schedule; PRESENT_DECRYPT_EN adds decrypt.
// Latency: done_o 32 cycles after accept (encrypt), 63 cycles (decrypt: 31 keygen + 31 rounds + final).
// Backpressure: start_i only sampled in IDLE; starts while busy are dropped, nothing is queued.
module present80_round_ctrl
    import present_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [79:0] key_i,
    input  logic [63:0] data_i,
`ifdef PRESENT_DECRYPT_EN
    input  logic        dec_i,
`endif
    output logic        busy_o,
    output logic        done_o,
    output logic [63:0] data_o
);

    present_fsm_e   fsm_q;
    present_fsm_e   fsm_d;
    present_state_t state_q;
    present_key_t   key_q;
    logic [4:0]     ctr_q;

    present_state_t rnd_in;
    present_state_t rnd_out;
    logic           rnd_dir;

    // Control strobes decoded from the current FSM state.
    logic ld;
    logic st_upd;
    logic key_fwd;
    logic ctr_inc;
    logic fin;
`ifdef PRESENT_DECRYPT_EN
    logic key_inv;
    logic ctr_dec;
`endif

    assign rnd_in = state_q ^ key_q[79:16];

`ifdef PRESENT_DECRYPT_EN
    assign rnd_dir = (fsm_q == ST_DEC);
`else
    assign rnd_dir = 1'b0;
`endif

    present_round u_round (
        .dir  (rnd_dir),
        .din  (rnd_in),
        .dout (rnd_out)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= ST_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Next-state logic: the counter value at each edge is the round being executed.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_IDLE: begin
                if (start_i) begin
`ifdef PRESENT_DECRYPT_EN
                    fsm_d = dec_i ? ST_KEYGEN : ST_ENC;
`else
                    fsm_d = ST_ENC;
`endif
                end
            end
            ST_ENC: begin
                if (ctr_q == LAST_RND) fsm_d = ST_FINAL;
            end
`ifdef PRESENT_DECRYPT_EN
            ST_KEYGEN: begin
                if (ctr_q == LAST_RND) fsm_d = ST_DEC;
            end
            ST_DEC: begin
                if (ctr_q == 5'd1) fsm_d = ST_FINAL;
            end
`endif
            ST_FINAL: begin
                fsm_d = ST_IDLE;
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    // Output decode; the counter saturates at its end value so it never wraps.
    always_comb begin
        ld      = 1'b0;
        st_upd  = 1'b0;
        key_fwd = 1'b0;
        ctr_inc = 1'b0;
        fin     = 1'b0;
`ifdef PRESENT_DECRYPT_EN
        key_inv = 1'b0;
        ctr_dec = 1'b0;
`endif
        case (fsm_q)
            ST_IDLE: begin
                ld = start_i;
            end
            ST_ENC: begin
                st_upd  = 1'b1;
                key_fwd = 1'b1;
                ctr_inc = (ctr_q != LAST_RND);
            end
`ifdef PRESENT_DECRYPT_EN
            ST_KEYGEN: begin
                key_fwd = 1'b1;
                ctr_inc = (ctr_q != LAST_RND);
            end
            ST_DEC: begin
                st_upd  = 1'b1;
                key_inv = 1'b1;
                ctr_dec = (ctr_q != 5'd1);
            end
`endif
            ST_FINAL: begin
                fin = 1'b1;
            end
            default: begin
                ld = 1'b0;
            end
        endcase
    end

    // Cipher state, key register and round counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            key_q   <= '0;
            ctr_q   <= '0;
        end else if (ld) begin
            state_q <= data_i;
            key_q   <= key_i;
            ctr_q   <= 5'd1;
        end else begin
            if (st_upd) state_q <= rnd_out;
            if (key_fwd) begin
                key_q <= key_update(key_q, ctr_q);
`ifdef PRESENT_DECRYPT_EN
            end else if (key_inv) begin
                key_q <= key_invupdate(key_q, ctr_q);
`endif
            end
            if (ctr_inc) ctr_q <= ctr_q + 5'd1;
`ifdef PRESENT_DECRYPT_EN
            if (ctr_dec) ctr_q <= ctr_q - 5'd1;
`endif
        end
    end

    // Registered handshake outputs; busy follows the next state so it drops in the done cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_o <= 1'b0;
            done_o <= 1'b0;
            data_o <= '0;
        end else begin
            busy_o <= (fsm_d != ST_IDLE);
            done_o <= fin;
            if (fin) data_o <= state_q ^ key_q[79:16];
        end
    end

endmodule

// File: tb/tb_present80_round_ctrl.sv
// Directed bench for present80_round_ctrl: known-answer vectors, handshake timing, reset abort.
// Latency: expects done 32 cycles (encrypt) / 63 cycles (decrypt) after the accept edge.
// Backpressure: exercises start held high, start during busy, and start in the done cycle.
module tb_present80_round_ctrl;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        start_i = 1'b0;
    logic [79:0] key_i   = '0;
    logic [63:0] data_i  = '0;
`ifdef PRESENT_DECRYPT_EN
    logic        dec_i   = 1'b0;
`endif
    logic        busy_o;
    logic        done_o;
    logic [63:0] data_o;

    int total = 0;
    int bad   = 0;

    logic [63:0] vec_pt  [4];
    logic [79:0] vec_key [4];
    logic [63:0] vec_ct  [4];

    present80_round_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .key_i   (key_i),
        .data_i  (data_i),
`ifdef PRESENT_DECRYPT_EN
        .dec_i   (dec_i),
`endif
        .busy_o  (busy_o),
        .done_o  (done_o),
        .data_o  (data_o)
    );

    always #5 clk = ~clk;

    // Step edges until done_o; cyc is the edge count after the call (-1 on timeout).
    task automatic wait_done(input int limit, output int cyc, output int nbusy);
        cyc   = -1;
        nbusy = 0;
        for (int n = 1; n <= limit; n++) begin
            @(posedge clk); #1;
            if (done_o) begin
                cyc = n;
                break;
            end
            if (!busy_o) nbusy++;
        end
    endtask

    task automatic test_reset();
        #12;
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done_o); end
        total++; if (data_o !== 64'h0) begin bad++; $display("FAIL reset_data: got %h want 0", data_o); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_encrypt();
        int cyc;
        int nbusy;
        for (int v = 0; v < 4; v++) begin
            start_i = 1'b1;
            data_i  = vec_pt[v];
            key_i   = vec_key[v];
            @(posedge clk); #1;
            start_i = 1'b0;
            data_i  = ~data_i;
            key_i   = ~key_i;
            total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL enc_busy[%0d]: got %b want 1", v, busy_o); end
            wait_done(40, cyc, nbusy);
            total++; if (cyc !== 32) begin bad++; $display("FAIL enc_latency[%0d]: got %0d want 32", v, cyc); end
            total++; if (data_o !== vec_ct[v]) begin bad++; $display("FAIL enc_data[%0d]: got %h want %h", v, data_o, vec_ct[v]); end
            total++; if (nbusy !== 0) begin bad++; $display("FAIL enc_busy_gap[%0d]: got %0d want 0", v, nbusy); end
            total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL enc_busy_in_done[%0d]: got %b want 0", v, busy_o); end
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int nbusy;
        start_i = 1'b1;
        data_i  = vec_pt[0];
        key_i   = vec_key[0];
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                data_i = vec_pt[k+1];
                key_i  = vec_key[k+1];
            end else begin
                start_i = 1'b0;
            end
            wait_done(40, cyc, nbusy);
            total++; if (cyc !== 32) begin bad++; $display("FAIL b2b_latency[%0d]: got %0d want 32", k, cyc); end
            total++; if (data_o !== vec_ct[k]) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", k, data_o, vec_ct[k]); end
            total++; if (nbusy !== 0) begin bad++; $display("FAIL b2b_busy_gap[%0d]: got %0d want 0", k, nbusy); end
            @(posedge clk); #1;
            if (k < 3) begin
                total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL b2b_accept[%0d]: busy got %b want 1", k, busy_o); end
            end else begin
                total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL b2b_no_extra: busy got %b want 0", busy_o); end
            end
        end
    endtask

    task automatic test_reset_abort();
        int cyc;
        int nbusy;
        start_i = 1'b1;
        data_i  = vec_pt[3];
        key_i   = vec_key[3];
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy_o); end
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL abort_done: got %b want 0", done_o); end
        total++; if (data_o !== 64'h0) begin bad++; $display("FAIL abort_data: got %h want 0", data_o); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        start_i = 1'b1;
        data_i  = vec_pt[0];
        key_i   = vec_key[0];
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_done(40, cyc, nbusy);
        total++; if (cyc !== 32) begin bad++; $display("FAIL abort_rerun_latency: got %0d want 32", cyc); end
        total++; if (data_o !== vec_ct[0]) begin bad++; $display("FAIL abort_rerun_data: got %h want %h", data_o, vec_ct[0]); end
    endtask

    task automatic test_start_in_done();
        int cyc;
        int nbusy;
        int nhold;
        start_i = 1'b1;
        data_i  = vec_pt[3];
        key_i   = vec_key[3];
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_done(40, cyc, nbusy);
        total++; if (data_o !== vec_ct[3]) begin bad++; $display("FAIL sid_first_data: got %h want %h", data_o, vec_ct[3]); end
        start_i = 1'b1;
        data_i  = vec_pt[0];
        key_i   = vec_key[0];
        @(posedge clk); #1;
        start_i = 1'b0;
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL sid_accept_busy: got %b want 1", busy_o); end
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL sid_accept_done: got %b want 0", done_o); end
        cyc   = -1;
        nhold = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done_o) begin
                cyc = n;
                break;
            end
            if (data_o !== vec_ct[3]) nhold++;
        end
        total++; if (nhold !== 0) begin bad++; $display("FAIL sid_data_hold: changed %0d cycles want 0", nhold); end
        total++; if (cyc !== 32) begin bad++; $display("FAIL sid_latency: got %0d want 32", cyc); end
        total++; if (data_o !== vec_ct[0]) begin bad++; $display("FAIL sid_data: got %h want %h", data_o, vec_ct[0]); end
    endtask

`ifdef PRESENT_DECRYPT_EN
    task automatic test_decrypt();
        int cyc;
        int nbusy;
        for (int v = 0; v < 4; v += 3) begin
            start_i = 1'b1;
            dec_i   = 1'b1;
            data_i  = vec_ct[v];
            key_i   = vec_key[v];
            @(posedge clk); #1;
            start_i = 1'b0;
            dec_i   = 1'b0;
            data_i  = ~data_i;
            total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL dec_busy[%0d]: got %b want 1", v, busy_o); end
            wait_done(80, cyc, nbusy);
            total++; if (cyc !== 63) begin bad++; $display("FAIL dec_latency[%0d]: got %0d want 63", v, cyc); end
            total++; if (data_o !== vec_pt[v]) begin bad++; $display("FAIL dec_data[%0d]: got %h want %h", v, data_o, vec_pt[v]); end
            total++; if (nbusy !== 0) begin bad++; $display("FAIL dec_busy_gap[%0d]: got %0d want 0", v, nbusy); end
        end
    endtask
`endif

    initial begin
        vec_pt[0]  = 64'h0;                    vec_key[0] = 80'h0;
        vec_pt[1]  = 64'h0;                    vec_key[1] = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
        vec_pt[2]  = 64'hFFFF_FFFF_FFFF_FFFF;  vec_key[2] = 80'h0;
        vec_pt[3]  = 64'hFFFF_FFFF_FFFF_FFFF;  vec_key[3] = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
        vec_ct[0]  = 64'h5579_C138_7B22_8445;
        vec_ct[1]  = 64'hE72C_46C0_F594_5049;
        vec_ct[2]  = 64'hA112_FFC7_2F68_417B;
        vec_ct[3]  = 64'h3333_DCD3_2132_10D2;

        test_reset();
        test_encrypt();
        test_back_to_back();
        test_reset_abort();
        test_start_in_done();
`ifdef PRESENT_DECRYPT_EN
        test_decrypt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/present80_round_ctrl.md
# present80_round_ctrl

Iterative PRESENT-80 block-cipher engine controller. It sequences one cipher round per clock over a shared S-box/permutation round datapath and owns the 64-bit state register, the 80-bit key register and the round counter. It runs the on-the-fly key schedule and presents a start/busy/done handshake to the bus-side wrapper. It sits between the memory-mapped crypto peripheral registers and the combinational round logic.

## Interface
Parameters:
- `ROUNDS`, default 31: number of full rounds. Fixed by the PRESENT standard; it exists only for the package constant.

Ports:
- `clk`  in  1  single clock, rising-edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start_i`  in  1  request; sampled only in IDLE
- `key_i`  in  80  cipher key; sampled on the start-accept edge
- `data_i`  in  64  plaintext or ciphertext; sampled on the start-accept edge
- `dec_i`  in  1  1 = decrypt; exists only with `PRESENT_DECRYPT_EN`
- `busy_o`  out  1  high while an operation is in flight
- `done_o`  out  1  one-cycle pulse; `data_o` is valid from this cycle
- `data_o`  out  64  result; held until the next `done_o`

## Operation
- FSM states: IDLE, ENC, FINAL. With the macro compiled in, KEYGEN and DEC are added.
- Accept edge E0: in IDLE with `start_i`=1, load `state`=`data_i` and `key`=`key_i`, and set `ctr`=1. Next state is ENC, or KEYGEN when `dec_i`=1.
- ENC, one edge per round i=1..31:
  - `state` ← P(S(`state` ^ `key`[79:16]))
  - `key` ← update(`key`, i)
  - `ctr`++
  - After i=31, go to FINAL.
- update(K,i), in this order:
  - rotate left by 61
  - [79:76] ← S([79:76])
  - [19:15] ^= i[4:0]
- FINAL (one edge): `data_o` ← `state` ^ `key`[79:16], `done_o`=1, go to IDLE.
- KEYGEN (31 edges): apply update(`key`, i) for i=1..31 only, leaving `state` untouched. Afterwards `key`=K32, `ctr`=31, go to DEC.
- DEC, one edge per i=31 down to 1:
  - `state` ← S⁻¹(P⁻¹(`state` ^ `key`[79:16]))
  - `key` ← invupdate(`key`, i)
  - `ctr`--
  - After i=1, go to FINAL. FINAL then yields `state` ^ K1[79:16].
- invupdate(K,i), in this order:
  - [19:15] ^= i[4:0]
  - [79:76] ← S⁻¹([79:76])
  - rotate right by 61
- The counter is 5 bits. It never wraps in normal operation: ENC ends at 31, DEC ends at 1.
- `start_i` while busy is ignored, with no queuing.
- `start_i` high in the cycle `done_o` is high is legal. The FSM is already in IDLE, so that start is accepted.
- `key_i`, `data_i` and `dec_i` may change freely after the accept edge.

## Timing
- Reset values: `busy_o`=0, `done_o`=0, `data_o`=64'h0, FSM=IDLE. `state`, `key` and `ctr` are also 0.
- Reset asserted mid-operation aborts immediately. No `done_o` is produced, and `data_o` returns to 0.
- `busy_o` is registered. It is 1 from the cycle after E0 through the cycle in which the FINAL edge occurs, and 0 in the `done_o` cycle.
- Encrypt latency: `done_o` is high in the cycle following edge E32. Throughput is one block per 33 cycles with back-to-back starts.
- Decrypt latency: `done_o` is high following edge E63 (31 KEYGEN + 31 DEC + FINAL).
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `PRESENT_DECRYPT_EN` defined: `dec_i` port, KEYGEN/DEC states, and the P⁻¹/S⁻¹ datapath are present.
- `PRESENT_DECRYPT_EN` undefined: encrypt-only. There is no `dec_i` port, every start runs ENC, and the inverse logic is absent.

## Structure
- Package `present_pkg`:
  - S-box and inverse S-box 16×4 constant arrays
  - `ROUNDS`=31
  - state typedef `present_state_t` (logic [63:0])
  - key typedef `present_key_t` (logic [79:0])
  - FSM enum `present_fsm_e`
  - functions `key_update`, `key_invupdate`
- Sub-module `present_round`: combinational S-layer plus P-layer. It has a `dir` input, with an inverse path present only under the macro. The controller instantiates it once.

## Test plan
- data 64'h0, key 80'h0, encrypt → `done_o` 32 cycles after accept, `data_o`=64'h5579C1387B228445.
- data 64'h0, key 80'hFFFF_FFFFFFFF_FFFFFFFF → 64'hE72C46C0F5945049. data all-ones, key 0 → 64'hA112FFC72F68417B. data all-ones, key all-ones → 64'h3333DCD3213210D2.
- Macro on: decrypt 64'h3333DCD3213210D2 with key all-ones → `data_o`=64'hFFFFFFFFFFFFFFFF, `done_o` 63 cycles after accept.
- `start_i` held high continuously with new data each accept → exactly one accept per 33 cycles. Each `done_o` matches the data sampled at its accept edge, and no start is taken while `busy_o`=1.
- `rst_n` pulsed low at round 15 → `busy_o`, `done_o` and `data_o` go to 0 asynchronously. A following start with data/key 0 still yields 64'h5579C1387B228445.
- `start_i` asserted in the `done_o` cycle → accepted on that edge. `busy_o`=1 in the next cycle, and `data_o` keeps the old result until the new `done_o`.
